// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding mux
// encodings, memory-wait FSM states and the bundle of stall/flush controls.
package hazard_ctrl_unit_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hazard_ctrl_t;

  // Memory stage result is younger than writeback, so it wins; x0 is never a
  // real producer and must not be forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic             reg_write_m,
    input logic [REG_W-1:0] rd_m,
    input logic             reg_write_w,
    input logic [REG_W-1:0] rd_w,
    input logic [REG_W-1:0] rs
  );
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) return FWD_M;
    if (reg_write_w && (rd_w != '0) && (rd_w == rs)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  // NOTE: registers are updated with non-blocking assignments and reset
  // asynchronously, so every flop sees pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for a 5-stage pipeline: operand forwarding, load-use stall,
// taken-branch flush, and a dmem wait FSM with a timeout watchdog.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             ResultSrcE0,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned       WCNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q;
  logic              timeout_set;
  logic              force_release;
  logic              mem_wait;
  logic              lw_stall;
  hazard_ctrl_t      ctrl;

  assign ForwardAE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
  assign ForwardBE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);

  assign force_release = (state_q == ST_WAIT) && (wait_cnt_q == TIMEOUT_V);
  assign mem_wait      = MemAccessM && !dmem_ready && !force_release;
  assign lw_stall      = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Stalls and flushes are also gated by reset so an in-flight memory wait
  // cannot keep the pipeline frozen while it is being reset.
  always_comb begin
    // NOTE: every combinational output gets a default first; otherwise any
    // path that skips an assignment infers a latch.
    ctrl = '0;
    if (!reset_n) begin
      ctrl = '0;
    end else if (mem_wait) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.stall_e = 1'b1;
      ctrl.stall_m = 1'b1;
      ctrl.flush_w = 1'b1;
    end else if (PCSrcE) begin
      ctrl.flush_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end else if (lw_stall) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end
  end

  assign StallF = ctrl.stall_f;
  assign StallD = ctrl.stall_d;
  assign StallE = ctrl.stall_e;
  assign StallM = ctrl.stall_m;
  assign FlushD = ctrl.flush_d;
  assign FlushE = ctrl.flush_e;
  assign FlushW = ctrl.flush_w;

  // wait_cnt counts stalled cycles of the current access, including the
  // first one spent in RUN, so the watchdog fires on the TIMEOUT-th WAIT cycle.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_set = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (dmem_ready || !MemAccessM) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (force_release) begin
          state_d     = ST_RUN;
          wait_cnt_d  = '0;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_q || timeout_set;
    end
  end

  assign mem_timeout = mem_timeout_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (StallF),
    .q       (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (FlushD),
    .q       (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit; counters are narrowed to 4 bits so the
// saturation point is reachable within the memory timeout scenario.
module tb_hazard_ctrl_unit;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 4;

  logic             clk;
  logic             reset_n;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemAccessM, dmem_ready;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  logic [6:0] hz;
  assign hz = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  localparam logic [6:0] HZ_NONE   = 7'b0000000;
  localparam logic [6:0] HZ_MEM    = 7'b1111001;
  localparam logic [6:0] HZ_BRANCH = 7'b0000110;
  localparam logic [6:0] HZ_LOAD   = 7'b1100010;

  typedef struct packed {
    logic       rwm;
    logic [4:0] rdm;
    logic       rww;
    logic [4:0] rdw;
    logic [4:0] rs1e;
    logic [4:0] rs2e;
    logic [1:0] ea;
    logic [1:0] eb;
  } fwd_vec_t;

  fwd_vec_t fwd_tbl [6];

  hazard_ctrl_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RdM         (RdM),
    .RdW         (RdW),
    .ResultSrcE0 (ResultSrcE0),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .PCSrcE      (PCSrcE),
    .MemAccessM  (MemAccessM),
    .dmem_ready  (dmem_ready),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench did not finish");
  end

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE0 = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; MemAccessM = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (hz !== HZ_NONE) $display("FAIL reset_hz: got %b want %b", hz, HZ_NONE);
    else n_pass++;
    n_checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0000)
      $display("FAIL reset_fwd: got %b want 0000", {ForwardAE, ForwardBE});
    else n_pass++;
    n_checks++;
    if ({mem_timeout, stall_cnt, flush_cnt} !== '0)
      $display("FAIL reset_state: got to=%b sc=%0d fc=%0d want 0/0/0", mem_timeout, stall_cnt, flush_cnt);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_mem_wait();
    MemAccessM = 1'b1;
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (hz !== HZ_MEM) $display("FAIL mem_wait_stall[%0d]: got %b want %b", i, hz, HZ_MEM);
      else n_pass++;
      next_cycle();
    end
    dmem_ready = 1'b1;
    #1;
    n_checks++;
    if (hz !== HZ_NONE) $display("FAIL mem_wait_release: got %b want %b", hz, HZ_NONE);
    else n_pass++;
    next_cycle();
    clear_inputs();
    #1;
    n_checks++;
    if (stall_cnt !== 4'd3 || flush_cnt !== 4'd0)
      $display("FAIL mem_wait_counts: got sc=%0d fc=%0d want 3/0", stall_cnt, flush_cnt);
    else n_pass++;
  endtask

  task automatic test_forward();
    //           rwm  rdm  rww  rdw  rs1e rs2e ea     eb
    fwd_tbl[0] = '{1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd0, 2'b10, 2'b00};
    fwd_tbl[1] = '{1'b1, 5'd0, 1'b1, 5'd5, 5'd5, 5'd0, 2'b01, 2'b00};
    fwd_tbl[2] = '{1'b1, 5'd9, 1'b1, 5'd5, 5'd5, 5'd9, 2'b01, 2'b10};
    fwd_tbl[3] = '{1'b0, 5'd9, 1'b1, 5'd9, 5'd3, 5'd9, 2'b00, 2'b01};
    fwd_tbl[4] = '{1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
    fwd_tbl[5] = '{1'b0, 5'd5, 1'b0, 5'd5, 5'd5, 5'd5, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      RegWriteM = fwd_tbl[i].rwm;
      RdM       = fwd_tbl[i].rdm;
      RegWriteW = fwd_tbl[i].rww;
      RdW       = fwd_tbl[i].rdw;
      Rs1E      = fwd_tbl[i].rs1e;
      Rs2E      = fwd_tbl[i].rs2e;
      #1;
      n_checks++;
      if (ForwardAE !== fwd_tbl[i].ea || ForwardBE !== fwd_tbl[i].eb)
        $display("FAIL forward[%0d]: got A=%b B=%b want A=%b B=%b",
                 i, ForwardAE, ForwardBE, fwd_tbl[i].ea, fwd_tbl[i].eb);
      else n_pass++;
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd0; Rs2D = 5'd7;
    #1;
    n_checks++;
    if (hz !== HZ_LOAD) $display("FAIL load_use_rs2: got %b want %b", hz, HZ_LOAD);
    else n_pass++;
    next_cycle();
    RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    #1;
    n_checks++;
    if (hz !== HZ_NONE) $display("FAIL load_use_x0: got %b want %b", hz, HZ_NONE);
    else n_pass++;
    next_cycle();
    RdE = 5'd7; Rs1D = 5'd7; Rs2D = 5'd3;
    #1;
    n_checks++;
    if (hz !== HZ_LOAD) $display("FAIL load_use_rs1: got %b want %b", hz, HZ_LOAD);
    else n_pass++;
    next_cycle();
    ResultSrcE0 = 1'b0;
    #1;
    n_checks++;
    if (hz !== HZ_NONE) $display("FAIL load_use_not_load: got %b want %b", hz, HZ_NONE);
    else n_pass++;
    next_cycle();
    clear_inputs();
    #1;
    n_checks++;
    if (stall_cnt !== 4'd5) $display("FAIL load_use_count: got %0d want 5", stall_cnt);
    else n_pass++;
  endtask

  task automatic test_branch();
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
    #1;
    n_checks++;
    if (hz !== HZ_BRANCH) $display("FAIL branch_over_load: got %b want %b", hz, HZ_BRANCH);
    else n_pass++;
    next_cycle();
    clear_inputs();
    #1;
    n_checks++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd5)
      $display("FAIL branch_counts: got fc=%0d sc=%0d want 1/5", flush_cnt, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_priority_and_drop();
    MemAccessM = 1'b1; dmem_ready = 1'b0; PCSrcE = 1'b1;
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    #1;
    n_checks++;
    if (hz !== HZ_MEM) $display("FAIL mem_over_branch: got %b want %b", hz, HZ_MEM);
    else n_pass++;
    next_cycle();
    clear_inputs();
    #1;
    n_checks++;
    if (hz !== HZ_NONE) $display("FAIL wait_drop: got %b want %b", hz, HZ_NONE);
    else n_pass++;
    next_cycle();
    n_checks++;
    if (mem_timeout !== 1'b0 || stall_cnt !== 4'd6 || flush_cnt !== 4'd1)
      $display("FAIL wait_drop_state: got to=%b sc=%0d fc=%0d want 0/6/1", mem_timeout, stall_cnt, flush_cnt);
    else n_pass++;
  endtask

  task automatic test_timeout();
    MemAccessM = 1'b1;
    dmem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_checks++;
      if (hz !== HZ_MEM) $display("FAIL timeout_stall[%0d]: got %b want %b", i, hz, HZ_MEM);
      else n_pass++;
      next_cycle();
    end
    #1;
    n_checks++;
    if (hz !== HZ_NONE || mem_timeout !== 1'b0)
      $display("FAIL timeout_release: got hz=%b to=%b want %b/0", hz, mem_timeout, HZ_NONE);
    else n_pass++;
    next_cycle();
    clear_inputs();
    #1;
    n_checks++;
    if (mem_timeout !== 1'b1 || stall_cnt !== 4'd15)
      $display("FAIL timeout_flag: got to=%b sc=%0d want 1/15", mem_timeout, stall_cnt);
    else n_pass++;
    ResultSrcE0 = 1'b1; RdE = 5'd4; Rs2D = 5'd4;
    next_cycle();
    clear_inputs();
    repeat (3) next_cycle();
    n_checks++;
    if (mem_timeout !== 1'b1 || stall_cnt !== 4'd15)
      $display("FAIL timeout_sticky_sat: got to=%b sc=%0d want 1/15", mem_timeout, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    MemAccessM = 1'b1;
    dmem_ready = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    n_checks++;
    if (hz !== HZ_MEM) $display("FAIL pre_reset_wait: got %b want %b", hz, HZ_MEM);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (hz !== HZ_NONE || mem_timeout !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0)
      $display("FAIL reset_mid_wait: got hz=%b to=%b sc=%0d fc=%0d want %b/0/0/0",
               hz, mem_timeout, stall_cnt, flush_cnt, HZ_NONE);
    else n_pass++;
    clear_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    MemAccessM = 1'b1;
    #1;
    n_checks++;
    if (hz !== HZ_MEM) $display("FAIL post_reset_wait: got %b want %b", hz, HZ_MEM);
    else n_pass++;
    next_cycle();
    dmem_ready = 1'b1;
    #1;
    n_checks++;
    if (hz !== HZ_NONE) $display("FAIL post_reset_release: got %b want %b", hz, HZ_NONE);
    else n_pass++;
    next_cycle();
    clear_inputs();
    #1;
    n_checks++;
    if (stall_cnt !== 4'd1 || mem_timeout !== 1'b0)
      $display("FAIL post_reset_count: got sc=%0d to=%b want 1/0", stall_cnt, mem_timeout);
    else n_pass++;
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_mem_wait();
    test_forward();
    test_load_use();
    test_branch();
    test_priority_and_drop();
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
